spi_follower: RTL
=================

Name: spi_follower

Overview:
- Dedicated SPI follower (responder) that sits opposite the existing leader/follower SPI controller.
- Receives an external SPI clock and active-low chip select, samples the leader's data line, and returns a word from a CPU-loaded transmit buffer on miso.
- Oversamples all SPI pins in the clk domain and presents received words to the CPU over a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser (minimum 2).
- IDLE_FILL, 16'hFFFF, word shifted out when no tx word is loaded at frame start.

Ports:
- clk  input  1  system clock; sclk_in period must be at least 8 clk periods.
- rst  input  1  asynchronous, active-high reset.
- cpol  input  1  clock polarity; latched at the cs_n falling edge.
- cpha  input  1  clock phase; latched at the cs_n falling edge.
- len16  input  1  1 = 16-bit frame, 0 = 8-bit frame (low byte); latched at the cs_n falling edge.
- sclk_in  input  1  SPI clock from the leader (asynchronous).
- cs_n  input  1  chip select from the leader, active low (asynchronous).
- mosi  input  1  serial data from the leader (asynchronous).
- miso  output  1  serial data to the leader.
- miso_oe  output  1  tristate enable for miso; 1 only while selected.
- tx_data  input  16  word to send; in 8-bit frames only [7:0] is used.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  single-entry tx holding register is empty.
- rx_data  output  16  last received word, zero-extended in 8-bit frames.
- rx_valid  output  1  rx_data holds an unread word.
- rx_ready  input  1  CPU accepts rx_data.
- overrun  output  1  sticky; set when a new word completes while rx_valid=1.
- underrun  output  1  sticky; set when a frame starts with the tx holding register empty.
- frame_err  output  1  one-cycle pulse when cs_n deasserts mid-frame.
- err_clr  input  1  clears overrun and underrun.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, underrun=0, frame_err=0, bit counter=0, state=IDLE. Synchronisers reset to sclk=cpol input value, cs_n=1, mosi=0.
- Synchronisation:
  - sclk_in, cs_n and mosi each pass through SYNC_STAGES flip-flops.
  - Edge detectors run on synchronised sclk and cs_n.
  - Pin-to-action latency: SYNC_STAGES+1 clk cycles.
- Edge selection:
  - sample_edge = sclk rising when cpol==cpha, falling otherwise.
  - shift_edge = the opposite edge.
- TX holding register:
  - Loaded when tx_valid && tx_ready; tx_ready then drops to 0.
  - Frees (tx_ready=1) when its contents are transferred to the shifter.
- States:
  - IDLE: miso_oe=0.
    - On cs_n fall: latch cpol/cpha/len16; load the shifter from the holding register, or from IDLE_FILL with underrun set if the holding register is empty.
    - Drive the MSB of the active length on miso; clear the bit counter; go to ACTIVE.
  - ACTIVE: miso_oe=1.
    - On sample_edge: shift the synchronised mosi into the rx shifter LSB and increment the counter.
    - On shift_edge: advance the tx shifter and drive the next bit. With cpha=1, the first shift_edge after selection is ignored because the MSB is already on miso.
    - When the counter reaches 8 or 16 (per len16): go to DONE.
  - DONE (1 cycle):
    - rx_data <= received word and rx_valid <= 1. If rx_valid was already 1 and rx_ready=0 in the same cycle, set overrun and overwrite rx_data.
    - Reload the tx shifter as at frame start, with the same underrun rule; clear the counter; return to ACTIVE. Back-to-back frames under one cs_n are supported.
- rx_valid clears on rx_valid && rx_ready. If DONE coincides with the accept, the new word wins: rx_valid stays 1 and no overrun is flagged.
- cs_n rise:
  - In ACTIVE with counter != 0: discard the partial word, pulse frame_err, go to IDLE.
  - Counter == 0: go to IDLE silently.
  - An untransmitted shifter word is lost; the holding register is untouched.
- err_clr has priority over a same-cycle set (clear wins).
- Config input changes while cs_n is low are ignored until the next frame.
- Asserting rst mid-frame returns immediately to reset values.

Optional Feature:
- SPI_FOLLOWER_LSB_FIRST_EN defined: transmit and receive LSB first. The first bit driven is tx[0]; received bits enter at the MSB of the active length and shift right.
- Undefined: MSB first as described above.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, ACTIVE, DONE), length constants LEN8=8 and LEN16=16, and the edge-select function (cpol, cpha) -> sample on rising edge. The existing controller reuses the same package.
- One natural sub-module: spi_sync_edge, a parameterised synchroniser plus rise/fall detector, instantiated for sclk_in and cs_n. mosi uses a plain synchroniser.

Test Plan:
- Mode 0, len16=0, tx=8'hA5 preloaded, leader sends 8'h3C: miso bit stream 1,0,1,0,0,1,0,1; rx_data=16'h003C; rx_valid=1; underrun=0.
- Mode 3, len16=1, tx=16'hBEEF, leader sends 16'h1234: miso yields 16'hBEEF MSB first; rx_data=16'h1234; first shift edge ignored.
- Two back-to-back 8-bit frames under one cs_n with tx_valid not re-asserted: the second frame sends 8'hFF, underrun=1; rx_ready held at 0 gives overrun=1 and rx_data = second word.
- cs_n raised after 5 of 8 bits in mode 1: frame_err pulses once, rx_valid stays 0, the next frame receives 8'h81 correctly.
- DONE coincides with rx_ready=1 accept: rx_valid stays 1 with the new word, overrun=0.
- rst asserted mid-frame: all outputs return to reset values within 1 cycle; miso_oe=0 while cs_n is still low.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, frame lengths, config payload and edge selection.
// Used by both the follower and the leader/follower controller.
package spi_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LEN8   = 8;
  localparam int unsigned LEN16  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic len16;
  } spi_cfg_t;

  // Data is sampled on the rising sclk edge when cpol and cpha agree.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall detection
// on the synchronised value. The reset level is supplied by the parent.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{rst_val}};
      prev_q <= rst_val;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_follower.sv
// SPI follower: oversampled sclk/cs_n/mosi, tx holding register, rx valid/ready.
// Define SPI_FOLLOWER_LSB_FIRST_EN for LSB-first transmit and receive.
module spi_follower
  import spi_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] IDLE_FILL   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              len16,
  input  logic              sclk_in,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              underrun,
  output logic              frame_err,
  input  logic              err_clr
);

  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .rst_val(cpol),
    .din    (sclk_in),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .rst_val(1'b1),
    .din    (cs_n),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  spi_cfg_t          cfg_q, cfg_d;
  logic [WORD_W-1:0] tx_hold_q, tx_hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0] rx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              skip_q, skip_d;
  logic              tx_ready_d, miso_d, miso_oe_d, rx_valid_d;
  logic              overrun_d, underrun_d, frame_err_d;
  logic              load_c, sample_edge_c, shift_edge_c;

  assign sample_edge_c = sample_on_rise(cfg_q.cpol, cfg_q.cpha) ? sclk_rise_c : sclk_fall_c;
  assign shift_edge_c  = sample_on_rise(cfg_q.cpol, cfg_q.cpha) ? sclk_fall_c : sclk_rise_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      tx_hold_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      cnt_q     <= '0;
      skip_q    <= 1'b0;
      tx_ready  <= 1'b1;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      tx_hold_q <= tx_hold_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      tx_ready  <= tx_ready_d;
      miso      <= miso_d;
      miso_oe   <= miso_oe_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      overrun   <= overrun_d;
      underrun  <= underrun_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    tx_hold_d   = tx_hold_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    tx_ready_d  = tx_ready;
    miso_d      = miso;
    miso_oe_d   = miso_oe;
    rx_data_d   = rx_data;
    rx_valid_d  = rx_valid;
    overrun_d   = overrun;
    underrun_d  = underrun;
    frame_err_d = 1'b0;
    load_c      = 1'b0;

    if (tx_valid && tx_ready) begin
      tx_hold_d  = tx_data;
      tx_ready_d = 1'b0;
    end
    if (rx_valid && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_oe_d = 1'b0;
        if (cs_fall_c) begin
          cfg_d     = '{cpol: cpol, cpha: cpha, len16: len16};
          load_c    = 1'b1;
          skip_d    = cpha;
          miso_oe_d = 1'b1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise_c) begin
          frame_err_d = (cnt_q != '0);
          miso_oe_d   = 1'b0;
          state_d     = IDLE;
        end else if (sample_edge_c) begin
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
          rx_sh_d = cfg_q.len16 ? {mosi_s, rx_sh_q[WORD_W-1:1]} : {8'h00, mosi_s, rx_sh_q[7:1]};
`else
          rx_sh_d = {rx_sh_q[WORD_W-2:0], mosi_s};
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == (cfg_q.len16 ? CNT_W'(LEN16) : CNT_W'(LEN8))) state_d = DONE;
        end else if (shift_edge_c) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
            tx_sh_d = {1'b0, tx_sh_q[WORD_W-1:1]};
            miso_d  = tx_sh_d[0];
`else
            tx_sh_d = {tx_sh_q[WORD_W-2:0], 1'b0};
            miso_d  = cfg_q.len16 ? tx_sh_d[15] : tx_sh_d[7];
`endif
          end
        end
      end
      DONE: begin
        rx_data_d  = cfg_q.len16 ? rx_sh_q : {8'h00, rx_sh_q[7:0]};
        rx_valid_d = 1'b1;
        if (rx_valid && !rx_ready) overrun_d = 1'b1;
        if (cs_rise_c) begin
          miso_oe_d = 1'b0;
          state_d   = IDLE;
        end else begin
          // Next word's first bit is already driven; the following shift edge
          // (trailing edge for cpha=0, leading edge for cpha=1) must not advance it.
          load_c  = 1'b1;
          skip_d  = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      if (tx_ready) begin
        tx_sh_d    = IDLE_FILL;
        underrun_d = 1'b1;
      end else begin
        tx_sh_d    = tx_hold_q;
        tx_ready_d = 1'b1;
      end
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
      miso_d = tx_sh_d[0];
`else
      miso_d = cfg_d.len16 ? tx_sh_d[15] : tx_sh_d[7];
`endif
      cnt_d = '0;
    end

    if (err_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

endmodule
